// File: rtl/bus_demux4_32_pkg.sv
// bus_demux4_32_pkg: shared state encoding, slave indices and select helper for the request router
package bus_demux4_32_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;
  localparam logic [1:0] SLV_RAM = 2'd0;
  localparam logic [1:0] SLV_ROM = 2'd1;
  localparam logic [1:0] SLV_IO  = 2'd2;
  localparam logic [1:0] SLV_VGA = 2'd3;
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/bus_rdata_sel4.sv
// bus_rdata_sel4: 4:1 selector of slave read data by the latched slave index
module bus_rdata_sel4
  import bus_demux4_32_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [31:0] rdata0_i,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  input  logic [31:0] rdata3_i,
  output logic [31:0] rdata_o
);
  always_comb begin
    rdata_o = sel_i == SLV_RAM ? rdata0_i :
              sel_i == SLV_ROM ? rdata1_i :
              sel_i == SLV_IO  ? rdata2_i : rdata3_i;
  end
endmodule

// File: rtl/bus_demux4_32.sv
// bus_demux4_32: 1-to-4 system bus request router with per-request timeout
module bus_demux4_32
  import bus_demux4_32_pkg::*;
#(
  parameter int SEL_LSB = 30,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic        busy,
  output logic [3:0]  s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [3:0]  s_ack,
  input  logic [31:0] s_rdata0,
  input  logic [31:0] s_rdata1,
  input  logic [31:0] s_rdata2,
  input  logic [31:0] s_rdata3
);
  state_e        state_q;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   sel_rdata;
  bus_rdata_sel4 u_sel (
    .sel_i   (sel_q),
    .rdata0_i(s_rdata0),
    .rdata1_i(s_rdata1),
    .rdata2_i(s_rdata2),
    .rdata3_i(s_rdata3),
    .rdata_o (sel_rdata)
  );
  // decoded from state so an async reset drops the slave request immediately
  assign m_ack = state_q == RESP;
  assign busy  = state_q != IDLE;
  assign s_req = state_q == REQ ? onehot4(sel_q) : 4'b0000;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_rdata <= '0;
      m_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (m_req) begin
          s_we    <= m_we;
          s_addr  <= m_addr;
          s_wdata <= m_wdata;
          sel_q   <= m_addr[SEL_LSB+1:SEL_LSB];
          cnt_q   <= '0;
          state_q <= REQ;
        end
        REQ: if (s_ack[sel_q]) begin
          m_rdata <= sel_rdata;
          m_err   <= 1'b0;
          state_q <= RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          m_rdata <= '0;
          m_err   <= 1'b1;
          state_q <= RESP;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_demux4_32.sv
// tb_bus_demux4_32: table-driven scoreboard bench for the 4-way bus request router
module tb_bus_demux4_32;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we, m_ack, m_err, busy, s_we;
  logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata;
  logic [3:0]  s_req, s_ack;
  logic [31:0] s_rdata0, s_rdata1, s_rdata2, s_rdata3;
  bus_demux4_32 #(.SEL_LSB(30), .TIMEOUT(TO), .CW(16)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .busy(busy), .s_req(s_req), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata0(s_rdata0), .s_rdata1(s_rdata1),
    .s_rdata2(s_rdata2), .s_rdata3(s_rdata3)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  noise;
    logic [3:0]  exp_sreq;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];
  vec_t vt[5];
  int checks = 0, failures = 0, acks = 0;
  always @(negedge clk) if (m_ack) acks++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int dly, input logic [3:0] noise,
                              input logic [3:0] sreq, input logic err, input logic [31:0] erd,
                              input int lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly; v.noise = noise;
    v.exp_sreq = sreq; v.exp_err = err; v.exp_rdata = erd; v.exp_lat = lat;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int  tgt, n;
    bit  done;
    exp_t e;
    tgt = int'(v.addr[31:30]);
    m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata; s_ack = 4'b0000;
    s_rdata0 = 32'h1111_1111; s_rdata1 = 32'h2222_2222;
    s_rdata2 = 32'h3333_3333; s_rdata3 = 32'h4444_4444;
    case (tgt)
      0: s_rdata0 = v.rdata;
      1: s_rdata1 = v.rdata;
      2: s_rdata2 = v.rdata;
      default: s_rdata3 = v.rdata;
    endcase
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    sb.push_back(e);
    n = 0; done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (m_ack) begin
        done = 1;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty: got m_ack with no pending request");
        end else begin
          e = sb.pop_front();
          chk("latency", n, e.lat);
          chk("m_rdata", m_rdata, e.rdata);
          chk("m_err", m_err, e.err);
          chk("s_req_resp", s_req, 4'b0000);
        end
      end else begin
        chk("s_req", s_req, v.exp_sreq);
        chk("s_addr", s_addr, v.addr);
        chk("s_wdata", s_wdata, v.wdata);
        chk("s_we", s_we, v.we);
        m_addr = ~v.addr; m_wdata = $urandom; m_we = ~v.we;
        s_ack = (v.noise & ~(4'b0001 << tgt)) | ((n == v.dly) ? (4'b0001 << tgt) : 4'b0000);
      end
    end
    if (!done) begin
      checks++; failures++; void'(sb.pop_front());
      $display("FAIL ack_wait: no m_ack within 20 cycles");
    end
    m_req = 1'b0; s_ack = 4'b0000;
    @(negedge clk);
    chk("m_ack_pulse", m_ack, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask
  initial begin
    int a0;
    rst = 1'b1; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; s_ack = 0;
    s_rdata0 = 0; s_rdata1 = 0; s_rdata2 = 0; s_rdata3 = 0;
    vt[0] = mk(1'b0, 32'h8000_0010, 32'h0, 32'h1234_5678, 3, 4'b1011, 4'b0100, 1'b0, 32'h1234_5678, 4);
    vt[1] = mk(1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 1, 4'b0000, 4'b0001, 1'b0, 32'h0, 2);
    vt[2] = mk(1'b0, 32'h4000_0000, 32'h0, 32'h5555_AAAA, 0, 4'b1101, 4'b0010, 1'b1, 32'h0, 5);
    vt[3] = mk(1'b0, 32'hC000_0020, 32'h0, 32'hA5A5_0F0F, 4, 4'b0000, 4'b1000, 1'b0, 32'hA5A5_0F0F, 5);
    vt[4] = mk(1'b1, 32'h4000_0100, 32'h0BAD_CAFE, 32'hDEAD_BEEF, 2, 4'b0001, 4'b0010, 1'b0, 32'hDEAD_BEEF, 3);
    repeat (2) @(negedge clk);
    chk("rst_m_ack", m_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_req", s_req, 4'b0000);
    chk("rst_s_we", s_we, 1'b0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m_err", m_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run(vt[i]);
    run(vt[2]);
    s_rdata1 = 32'hBAD0_BAD0; s_ack = 4'b0010;
    repeat (3) @(negedge clk);
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_m_ack", m_ack, 1'b0);
    chk("late_ack_m_err", m_err, 1'b1);
    chk("late_ack_m_rdata", m_rdata, 32'h0);
    s_ack = 4'b0000;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0000;
    repeat (2) @(negedge clk);
    chk("mid_req_s_req", s_req, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_s_req", s_req, 4'b0000);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_m_err", m_err, 1'b0);
    m_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a0 = acks;
    repeat (8) @(negedge clk);
    #1;
    chk("no_ack_after_rst", acks - a0, 0);
    a0 = acks;
    run(vt[1]);
    run(vt[0]);
    #1;
    chk("back_to_back_acks", acks - a0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_demux4_32.md
Name: bus_demux4_32

Overview:
- 1-to-4 request router for the multicycle CPU system bus; the write/request direction of the system bus.
- Accepts one CPU memory request at a time and decodes two address bits to pick one of four slave ports.
- Drives the chosen slave's request until it acknowledges, then returns its read data to the CPU.
- Unresponsive slaves are cut off by a timeout, which produces an error response.

Parameters:
- SEL_LSB, 30, low bit of the 2-bit slave-select field in m_addr (select = m_addr[SEL_LSB+1:SEL_LSB]).
- TIMEOUT, 255, maximum cycles spent in REQ waiting for s_ack before an error response (1..65535).
- CW, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m_req  in  1  CPU request; held high until m_ack is seen
- m_we  in  1  1 = write, 0 = read
- m_addr  in  32  byte address
- m_wdata  in  32  write data
- m_ack  out  1  one-cycle completion pulse
- m_err  out  1  valid with m_ack; 1 = timeout
- m_rdata  out  32  read data, valid with m_ack
- busy  out  1  high in any state other than IDLE
- s_req  out  4  one-hot request to slaves 0..3
- s_we  out  1  latched write enable, shared by all slaves
- s_addr  out  32  latched address, shared by all slaves
- s_wdata  out  32  latched write data, shared by all slaves
- s_ack  in  4  per-slave acknowledge
- s_rdata0..s_rdata3  in  32 each  per-slave read data

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - m_ack, m_err, busy, s_req and s_we = 0.
  - m_rdata, s_addr, s_wdata = 0.
  - Timeout counter = 0.
  - A reset asserted mid-transaction drops s_req the same instant. No m_ack is ever issued for an aborted transaction.
- State machine: IDLE, REQ, RESP. All outputs are registered or decoded from state and registers only. There are no combinational paths from inputs to outputs.
- IDLE:
  - When m_req=1: latch m_we, m_addr, m_wdata into s_we/s_addr/s_wdata; latch sel; clear the counter; go to REQ.
  - When m_req=0: hold all outputs.
- REQ:
  - s_req = one-hot(sel); all other bits are 0.
  - When s_ack[sel]=1: latch s_rdata<sel> into m_rdata, set m_err=0, go to RESP.
  - Else if counter == TIMEOUT-1: set m_rdata=0, m_err=1, go to RESP.
  - Otherwise the counter increments by 1.
- RESP:
  - m_ack=1 for exactly one cycle; s_req=0; next state is IDLE unconditionally.
- Ack rules:
  - s_ack bits of non-selected slaves are ignored at all times.
  - All s_ack bits are ignored in IDLE and RESP. A late ack after a timeout has no effect.
- Ack and timeout in the same REQ cycle: the ack wins and m_err=0.
- Latency: a request seen in cycle 0 whose slave acks in the first REQ cycle (cycle 1) gives m_ack in cycle 2. Each extra wait cycle adds 1.
- Master rule: m_req is deasserted in the cycle after m_ack. If m_req is still high in IDLE, it is treated as a new request.
- Changes to m_addr/m_wdata/m_we after acceptance do not affect the slave-side signals.
- m_rdata and m_err hold their values after m_ack until the next RESP. m_rdata is 0 for writes only if the slave returns 0; it is passed through unmodified.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, REQ=2'd1, RESP=2'd2.
  - Slave index constants: SLV_RAM=0, SLV_ROM=1, SLV_IO=2, SLV_VGA=3.
- One sub-module, bus_rdata_sel4: a combinational 4:1 32-bit selector of s_rdata0..3 by the latched sel, feeding the m_rdata register.

Test Plan:
- Read, slave 2: m_req=1, m_we=0, m_addr=0x8000_0010; s_ack[2] rises on the 3rd REQ cycle with s_rdata2=0x1234_5678 -> s_req=4'b0100 throughout REQ; m_ack pulses once with m_rdata=0x1234_5678, m_err=0, 4 cycles after acceptance.
- Write, slave 0: m_addr=0x0000_0004, m_wdata=0xCAFE_F00D, m_we=1; m_addr changed after acceptance -> s_addr=0x0000_0004, s_wdata=0xCAFE_F00D, s_we=1 held stable until ack.
- Wrong-slave ack: target slave 1 with s_ack=4'b1101 held -> no m_ack; timeout at TIMEOUT=4 gives m_ack with m_err=1 and m_rdata=0 in the 5th cycle after acceptance; a later s_ack[1] is ignored.
- Ack on the timeout cycle: TIMEOUT=4, s_ack[3] in the 4th REQ cycle -> m_err=0, m_rdata=s_rdata3.
- Reset mid-REQ: assert rst asynchronously while s_req=4'b0010 -> s_req=0, busy=0 immediately; no m_ack after release.
- Back-to-back: second m_req raised the cycle after m_ack -> accepted, correct slave selected, two distinct m_ack pulses.
